// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and stall controller for a simple in-order pipeline. Decides, each
//   cycle, whether the PC and IF/ID register advance, whether IF/ID or ID/EX
//   receive a bubble, and whether the core has halted.
//
//   Sources of stall/flush, in priority order while running:
//     load-use hazard > taken branch > HLT in ID > instruction-memory miss.
//   A miss holds the PC for exactly MISS_LAT cycles, including the cycle the
//   miss is detected. HLT is sticky until reset.
//
// Parameters
//   MISS_LAT     instruction-memory miss penalty in cycles (legal 2..15)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   ex_mem_read  instruction in EX is a load
//   ex_dst       destination register of the instruction in EX
//   id_src1/2    source registers of the instruction in ID
//   id_use1/2    the matching ID source is actually read
//   branch_taken branch resolved taken in ID this cycle
//   hlt_id       HLT is in ID
//   imem_miss    current fetch missed
//   pc_wen       PC write enable
//   ifid_wen     IF/ID write enable
//   ifid_flush   load NOP into IF/ID instead of the fetched instruction
//   idex_flush   insert a bubble into ID/EX
//   halted       core is halted
//   stall_count  (HAZARD_STALL_CNT_EN only) saturating count of cycles with
//                pc_wen=0 outside HALT
//   state_dbg    current FSM state, for observation only
//
// Optional build macro: HAZARD_STALL_CNT_EN adds the stall_count output.
//
// Handshake note: there is no valid/ready handshake here; every input is a
// same-cycle level and every output is combinational from state and inputs.

module pipe_hazard_ctrl #(
  parameter int MISS_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_mem_read,
  input  logic [3:0]  ex_dst,
  input  logic [3:0]  id_src1,
  input  logic [3:0]  id_src2,
  input  logic        id_use1,
  input  logic        id_use2,
  input  logic        branch_taken,
  input  logic        hlt_id,
  input  logic        imem_miss,
  output logic        pc_wen,
  output logic        ifid_wen,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        halted,
`ifdef HAZARD_STALL_CNT_EN
  output logic [15:0] stall_count,
`endif
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] RUN       = 2'b00;
  localparam logic [1:0] MISS_WAIT = 2'b01;
  localparam logic [1:0] HALT      = 2'b10;

  // The detect cycle counts as the first hold cycle, and MISS_WAIT runs for
  // miss_cnt values (MISS_LAT-2) down to 0, giving MISS_LAT-1 more cycles.
  localparam logic [3:0] MISS_LOAD = 4'(MISS_LAT - 2);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] miss_cnt;
  logic [3:0] miss_cnt_nxt;
  logic       lu;

  // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign lu = ex_mem_read && (ex_dst != 4'd0) &&
              ((id_use1 && (id_src1 == ex_dst)) ||
               (id_use2 && (id_src2 == ex_dst)));

  assign state_dbg = state;

  always_comb begin
    pc_wen       = 1'b1;
    ifid_wen     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    halted       = 1'b0;
    state_nxt    = state;
    miss_cnt_nxt = miss_cnt;
    case (state)
      RUN: begin
        if (lu) begin
          // Freeze fetch and decode, bubble EX; other events retry next cycle.
          pc_wen     = 1'b0;
          ifid_wen   = 1'b0;
          idex_flush = 1'b1;
        end else if (branch_taken) begin
          // PC takes the target; the wrong-path fetch (and any miss on it) is dropped.
          ifid_flush = 1'b1;
        end else if (hlt_id) begin
          pc_wen     = 1'b0;
          ifid_flush = 1'b1;
          state_nxt  = HALT;
        end else if (imem_miss) begin
          pc_wen       = 1'b0;
          ifid_flush   = 1'b1;
          state_nxt    = MISS_WAIT;
          miss_cnt_nxt = MISS_LOAD;
        end
      end
      MISS_WAIT: begin
        // ID only sees bubbles here, so hazard/branch/halt inputs are ignored.
        pc_wen     = 1'b0;
        ifid_flush = 1'b1;
        if (miss_cnt == 4'd0) begin
          state_nxt = RUN;
        end else begin
          miss_cnt_nxt = miss_cnt - 4'd1;
        end
      end
      HALT: begin
        pc_wen     = 1'b0;
        ifid_flush = 1'b1;
        halted     = 1'b1;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      miss_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      miss_cnt <= miss_cnt_nxt;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= 16'd0;
    end else if (!pc_wen && (state != HALT) && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Directed scenarios followed by randomized stimulus, all checked against a
//   reference model that tracks "halted" and "cycles of miss penalty left".

module tb_pipe_hazard_ctrl;

  localparam int MISS_LAT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        ex_mem_read, id_use1, id_use2, branch_taken, hlt_id, imem_miss;
  logic [3:0]  ex_dst, id_src1, id_src2;
  logic        pc_wen, ifid_wen, ifid_flush, idex_flush, halted;
  logic [1:0]  state_dbg;
`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  pipe_hazard_ctrl #(.MISS_LAT(MISS_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_use1(id_use1), .id_use2(id_use2),
    .branch_taken(branch_taken), .hlt_id(hlt_id), .imem_miss(imem_miss),
    .pc_wen(pc_wen), .ifid_wen(ifid_wen), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .halted(halted),
`ifdef HAZARD_STALL_CNT_EN
    .stall_count(stall_count),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_halted;
  int m_miss_left;   // remaining penalty cycles after the current one
  int m_stall;

  logic o_pc, o_flush, o_halted, o_idex;   // last sampled observations

  task automatic model_reset();
    m_halted    = 1'b0;
    m_miss_left = 0;
    m_stall     = 0;
  endtask

  task automatic set_idle();
    ex_mem_read = 0; ex_dst = 0; id_src1 = 0; id_src2 = 0;
    id_use1 = 0; id_use2 = 0; branch_taken = 0; hlt_id = 0; imem_miss = 0;
  endtask

  // Drive one cycle's inputs on the falling edge, check combinational outputs
  // shortly after, then advance the model on the rising edge.
  task automatic run_cycle(input logic emr, input logic [3:0] dst,
                           input logic [3:0] s1, input logic [3:0] s2,
                           input logic u1, input logic u2,
                           input logic br, input logic hl, input logic ms);
    logic e_pc, e_wen, e_ff, e_idex, e_halt;
    bit   hazard, stall_now, n_halted;
    int   n_miss;
    @(negedge clk);
    ex_mem_read = emr; ex_dst = dst; id_src1 = s1; id_src2 = s2;
    id_use1 = u1; id_use2 = u2; branch_taken = br; hlt_id = hl; imem_miss = ms;
    #1;
    hazard   = emr && (dst != 0) && ((u1 && s1 == dst) || (u2 && s2 == dst));
    n_halted = m_halted;
    n_miss   = m_miss_left;
    {e_pc, e_wen, e_ff, e_idex, e_halt} = 5'b11000;
    if (m_halted) begin
      {e_pc, e_wen, e_ff, e_idex, e_halt} = 5'b01101;
    end else if (m_miss_left > 0) begin
      {e_pc, e_wen, e_ff, e_idex, e_halt} = 5'b01100;
      n_miss = m_miss_left - 1;
    end else if (hazard) begin
      {e_pc, e_wen, e_ff, e_idex, e_halt} = 5'b00010;
    end else if (br) begin
      {e_pc, e_wen, e_ff, e_idex, e_halt} = 5'b11100;
    end else if (hl) begin
      {e_pc, e_wen, e_ff, e_idex, e_halt} = 5'b01100;
      n_halted = 1'b1;
    end else if (ms) begin
      {e_pc, e_wen, e_ff, e_idex, e_halt} = 5'b01100;
      n_miss = MISS_LAT - 1;
    end
    stall_now = !e_pc && !m_halted;
    o_pc = pc_wen; o_flush = ifid_flush; o_halted = halted; o_idex = idex_flush;
    check("pc_wen", 16'(pc_wen), 16'(e_pc));
    check("ifid_wen", 16'(ifid_wen), 16'(e_wen));
    check("ifid_flush", 16'(ifid_flush), 16'(e_ff));
    check("idex_flush", 16'(idex_flush), 16'(e_idex));
    check("halted", 16'(halted), 16'(e_halt));
`ifdef HAZARD_STALL_CNT_EN
    check("stall_count", stall_count, 16'(m_stall));
`endif
    @(posedge clk);
    m_halted    = n_halted;
    m_miss_left = n_miss;
    if (stall_now && m_stall < 16'hFFFF) m_stall++;
  endtask

  task automatic idle_cycle();
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset asserted away from any clock edge; outputs checked while held.
  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_pc_wen", 16'(pc_wen), 16'd1);
    check("rst_ifid_wen", 16'(ifid_wen), 16'd1);
    check("rst_ifid_flush", 16'(ifid_flush), 16'd0);
    check("rst_idex_flush", 16'(idex_flush), 16'd0);
    check("rst_halted", 16'(halted), 16'd0);
`ifdef HAZARD_STALL_CNT_EN
    check("rst_stall_count", stall_count, 16'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int low_cnt;
    set_idle();
    model_reset();
    #2;
    do_reset();

    // Load-use: exactly one stall cycle, then normal flow.
    run_cycle(1, 3, 3, 0, 1, 0, 0, 0, 0);
    check("lu_pc_hold", 16'(o_pc), 16'd0);
    check("lu_bubble", 16'(o_idex), 16'd1);
    idle_cycle();
    check("lu_release", 16'(o_pc), 16'd1);

    // Single-cycle miss pulse: PC held for exactly MISS_LAT cycles.
    low_cnt = 0;
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    if (!o_pc) low_cnt++;
    for (int i = 0; i < 8; i++) begin
      idle_cycle();
      if (!o_pc) low_cnt++;
    end
    check("miss_hold_cycles", 16'(low_cnt), 16'(MISS_LAT));

    // Branch with a simultaneous miss: flush, PC moves, no miss wait.
    run_cycle(0, 0, 0, 0, 0, 0, 1, 0, 1);
    check("br_miss_flush", 16'(o_flush), 16'd1);
    check("br_miss_pc", 16'(o_pc), 16'd1);
    idle_cycle();
    check("br_miss_no_wait", 16'(o_pc), 16'd1);

    // Hazard with branch: stall only, branch takes effect next cycle.
    run_cycle(1, 5, 0, 5, 0, 1, 1, 0, 0);
    check("lu_br_noflush", 16'(o_flush), 16'd0);
    run_cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("br_after_lu", 16'(o_flush), 16'd1);

    // Load to r0 is not a hazard.
    run_cycle(1, 0, 0, 0, 1, 1, 0, 0, 0);
    check("r0_no_stall", 16'(o_pc), 16'd1);

`ifdef HAZARD_STALL_CNT_EN
    // One load-use plus one miss.
    do_reset();
    run_cycle(1, 3, 3, 0, 1, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (6) idle_cycle();
    run_cycle(1, 0, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("stall_cnt_total", stall_count, 16'(1 + MISS_LAT));
`endif

    // Halt: sticky for 20 cycles of random inputs, cleared by reset.
    run_cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      run_cycle(1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      check("halt_sticky", 16'(o_halted), 16'd1);
    end
    @(negedge clk);
    #2;
    do_reset();
    check("halt_cleared", 16'(halted), 16'd0);

    // Randomized phase.
    for (int i = 0; i < 800; i++) begin
      logic [3:0] dst;
      dst = 4'($urandom_range(0, 3));
      if ((m_halted && $urandom_range(0, 9) == 0) || $urandom_range(0, 299) == 0) begin
        @(negedge clk);
        #2;
        do_reset();
      end
      run_cycle(1'($urandom_range(0, 1)), dst,
                4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 59) == 0),
                1'($urandom_range(0, 5) == 0));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
